// File: rtl/edc_pkg.sv
// Shared definitions for the bitstream packer: default geometry and FSM state encoding.
package edc_pkg;

  // Default output word width and input beat width.
  localparam int unsigned NDATA_DEFAULT = 128;
  localparam int unsigned WIN_DEFAULT   = 8;

  // FILL accepts beats; PEND holds a completed word until the output register frees up.
  typedef enum logic {
    StFill = 1'b0,
    StPend = 1'b1
  } pack_state_e;

  // Bit offset of beat idx inside the assembled word.
  function automatic int unsigned beat_offset(input int unsigned idx, input int unsigned win);
    return idx * win;
  endfunction

endpackage

// File: rtl/bitstream_packer.sv
// Packs WIN-bit input beats LSB-first into NDATA-bit words. A word closes on the last beat
// slot or on in_last; its payload length is reported in out_count and unused bits read zero.
module bitstream_packer
  import edc_pkg::*;
#(
  parameter int unsigned NDATA = NDATA_DEFAULT,
  parameter int unsigned WIN   = WIN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIN-1:0]          in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NDATA-1:0]        out_data,
  output logic [$clog2(NDATA):0]  out_count
);

  localparam int unsigned NBEAT     = NDATA / WIN;
  localparam int unsigned NDATA_LOG = $clog2(NDATA);
  localparam int unsigned BEAT_W    = $clog2(NBEAT) + 1;
  localparam int unsigned CNT_W     = NDATA_LOG + 1;

  pack_state_e             state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  // Holds the partial word in FILL and the completed-but-blocked word in PEND.
  logic [NDATA-1:0]        asm_q, asm_d;
  logic [CNT_W-1:0]        pend_cnt_q, pend_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [NDATA-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;

  logic                    accept;
  logic                    drain;
  logic                    word_done;
  logic [NDATA-1:0]        beat_word;
  logic [NDATA-1:0]        merged;
  logic [CNT_W-1:0]        merged_cnt;

  // Ready depends only on state and reset so upstream never sees a valid->ready loop.
  assign in_ready = (state_q == StFill) && !rst;

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign word_done = accept && (in_last || (beat_q == BEAT_W'(NBEAT - 1)));

  // Current beat shifted into its slot and merged with the bits gathered so far.
  always_comb begin
    beat_word  = NDATA'(in_data) << beat_offset(32'(beat_q), WIN);
    merged     = asm_q | beat_word;
    merged_cnt = CNT_W'((32'(beat_q) + 32'd1) * WIN);
  end

  // Next-state logic for the FILL/PEND controller and the output register.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    asm_d       = asm_q;
    pend_cnt_d  = pend_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    // A drained word leaves the register empty unless something reloads it below.
    if (drain) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (word_done) begin
            beat_d = '0;
            if (!out_valid_q || drain) begin
              out_valid_d = 1'b1;
              out_data_d  = merged;
              out_count_d = merged_cnt;
              asm_d       = '0;
            end else begin
              state_d    = StPend;
              asm_d      = merged;
              pend_cnt_d = merged_cnt;
            end
          end else begin
            asm_d  = merged;
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      StPend: begin
        // Hand the held word over in the drain cycle so out_valid never bubbles.
        if (drain) begin
          out_valid_d = 1'b1;
          out_data_d  = asm_q;
          out_count_d = pend_cnt_q;
          asm_d       = '0;
          pend_cnt_d  = '0;
          state_d     = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // State and registered outputs; reset drops any partial or held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      beat_q      <= '0;
      asm_q       <= '0;
      pend_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      asm_q       <= asm_d;
      pend_cnt_q  <= pend_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule
